// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter unit.
// Fetch-control states and the sequential PC increment.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT,
    TRAP
  } pc_state_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target selection and misaligned-target detection.
// Purely combinational; the caller decides when the result is used.
module next_pc_sel
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  branch,
  input  logic                  branch_ne,
  input  logic                  eq,
  input  logic                  jump,
  input  logic                  jalr,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  nonseq,
  output logic                  misaligned
);

  logic taken;

  assign pc_plus4 = pc + DATA_WIDTH'(PC_INC);
  assign taken    = branch & (eq ^ branch_ne);

  // Overlapping selects resolve in priority order.
  always_comb begin
    next_pc = pc_plus4;
    nonseq  = 1'b0;
    priority case (1'b1)
      jalr: begin
        next_pc = {alu_out[DATA_WIDTH-1:1], 1'b0};
        nonseq  = 1'b1;
      end
      jump: begin
        next_pc = pc + imm;
        nonseq  = 1'b1;
      end
      taken: begin
        next_pc = pc + imm;
        nonseq  = 1'b1;
      end
      default: begin
        next_pc = pc_plus4;
        nonseq  = 1'b0;
      end
    endcase
  end

  assign misaligned = nonseq & next_pc[1];

endmodule

// File: rtl/pc_unit.sv
// Program counter with fetch handshake, redirect pulse and
// sticky misaligned-target trap.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_ready,
  input  logic                  stall,
  input  logic                  branch,
  input  logic                  branch_ne,
  input  logic                  EQ,
  input  logic                  jump,
  input  logic                  jalr,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic [DATA_WIDTH-1:0] ALUout,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PCplus4,
  output logic                  imem_req,
  output logic                  redirect,
  output logic                  trap,
  output logic [31:0]           fetch_count
);

  pc_state_t             state_q;
  pc_state_t             state_n;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] next_pc;
  logic [31:0]           cnt_q;
  logic                  redirect_q;
  logic                  nonseq;
  logic                  misaligned;
  logic                  accept;
  logic                  active;

  next_pc_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sel (
    .pc        (pc_q),
    .imm       (ImmOp),
    .alu_out   (ALUout),
    .branch    (branch),
    .branch_ne (branch_ne),
    .eq        (EQ),
    .jump      (jump),
    .jalr      (jalr),
    .pc_plus4  (PCplus4),
    .next_pc   (next_pc),
    .nonseq    (nonseq),
    .misaligned(misaligned)
  );

  assign active   = (state_q == RUN) || (state_q == WAIT);
  assign imem_req = active & ~stall;
  assign accept   = imem_req & imem_ready;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      BOOT: state_n = RUN;
      RUN: begin
        if (accept && misaligned)
          state_n = TRAP;
        else if (imem_req && !imem_ready)
          state_n = WAIT;
      end
      WAIT: begin
        if (accept)
          state_n = misaligned ? TRAP : RUN;
      end
      TRAP: state_n = TRAP;
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      redirect_q <= accept & nonseq & ~misaligned
                    & (next_pc != PCplus4);
      if (accept) begin
        cnt_q <= cnt_q + 32'd1;
        // A bad target still consumes the fetch but freezes PC.
        if (!misaligned)
          pc_q <= next_pc;
      end
    end
  end

  assign PC          = pc_q;
  assign redirect    = redirect_q;
  assign trap        = (state_q == TRAP);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a
// behavioural fetch model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        branch_ne = 1'b0;
  logic        eq = 1'b0;
  logic        jump = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] alu = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        redirect;
  logic        trap;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_running;
  logic        m_trapped;
  logic        m_redirect;

  pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_ready (imem_ready),
    .stall      (stall),
    .branch     (branch),
    .branch_ne  (branch_ne),
    .EQ         (eq),
    .jump       (jump),
    .jalr       (jalr),
    .ImmOp      (imm),
    .ALUout     (alu),
    .PC         (pc),
    .PCplus4    (pc_plus4),
    .imem_req   (imem_req),
    .redirect   (redirect),
    .trap       (trap),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".cnt"}, fetch_count, m_cnt);
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, m_redirect});
    chk({tag, ".trap"}, {31'd0, trap}, {31'd0, m_trapped});
    chk({tag, ".req"}, {31'd0, imem_req},
        {31'd0, m_running & ~m_trapped & ~stall});
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_cnt      = 32'h0;
    m_running  = 1'b0;
    m_trapped  = 1'b0;
    m_redirect = 1'b0;
  endtask

  // Effect of one rising edge given the inputs now applied.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        ns;
    m_redirect = 1'b0;
    if (!m_running) begin
      m_running = 1'b1;
    end else if (!m_trapped && !stall && imem_ready) begin
      m_cnt = m_cnt + 32'd1;
      ns    = 1'b1;
      if (jalr)
        tgt = alu & ~32'd1;
      else if (jump)
        tgt = m_pc + imm;
      else if (branch && (eq != branch_ne))
        tgt = m_pc + imm;
      else begin
        tgt = m_pc + 32'd4;
        ns  = 1'b0;
      end
      if (ns && (tgt % 4 >= 2)) begin
        m_trapped = 1'b1;
      end else begin
        m_redirect = ns && (tgt != m_pc + 32'd4);
        m_pc       = tgt;
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clear_ctl();
    branch    = 1'b0;
    branch_ne = 1'b0;
    eq        = 1'b0;
    jump      = 1'b0;
    jalr      = 1'b0;
    imm       = '0;
    alu       = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset_rel");
  endtask

  initial begin
    logic [31:0] r;
    clear_ctl();
    model_reset();
    do_reset();

    // Sequential fetch from reset.
    imem_ready = 1'b1;
    step("boot");
    chk("boot_pc", pc, 32'h0);
    step("seq1");
    step("seq2");
    step("seq3");
    chk("seq_pc", pc, 32'hC);
    chk("seq_cnt", fetch_count, 32'd3);
    step("seq4");
    chk("at10", pc, 32'h10);

    // BEQ taken backwards, then not taken.
    branch = 1'b1;
    eq     = 1'b1;
    imm    = 32'hFFFF_FFF8;
    step("beq_t");
    chk("beq_t_pc", pc, 32'h8);
    chk("beq_t_red", {31'd0, redirect}, 32'd1);
    clear_ctl();
    step("after_beq");
    chk("red_pulse", {31'd0, redirect}, 32'd0);
    step("to10");
    branch = 1'b1;
    eq     = 1'b0;
    imm    = 32'hFFFF_FFF8;
    step("beq_nt");
    chk("beq_nt_pc", pc, 32'h14);
    clear_ctl();
    step("s18");
    step("s1c");
    step("s20");

    // JALR aligned then misaligned.
    jalr = 1'b1;
    alu  = 32'h101;
    step("jalr_ok");
    chk("jalr_pc", pc, 32'h100);
    clear_ctl();
    jump = 1'b1;
    imm  = 32'hFFFF_FF20;
    step("jal_back");
    chk("jal_back_pc", pc, 32'h20);
    clear_ctl();
    jalr = 1'b1;
    alu  = 32'h102;
    step("jalr_bad");
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_pc", pc, 32'h20);
    clear_ctl();
    for (int i = 0; i < 3; i++) step("trapped");
    chk("trap_req", {31'd0, imem_req}, 32'd0);
    do_reset();

    // Wait states at 0x40.
    step("boot2");
    jump = 1'b1;
    imm  = 32'h40;
    step("jal40");
    clear_ctl();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("wait");
    chk("wait_pc", pc, 32'h40);
    imem_ready = 1'b1;
    step("wait_done");
    chk("wait_pc2", pc, 32'h44);

    // Stall masks a jump.
    stall = 1'b1;
    jump  = 1'b1;
    imm   = 32'h100;
    step("stall1");
    step("stall2");
    chk("stall_pc", pc, 32'h44);
    stall = 1'b0;
    step("unstall");
    chk("unstall_pc", pc, 32'h144);
    clear_ctl();

    // Asynchronous reset while waiting.
    imem_ready = 1'b0;
    step("w1");
    step("w2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_cnt", fetch_count, 32'h0);
    check_all("async");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    check_all("async_rel");

    // Address wrap.
    step("boot3");
    jump = 1'b1;
    imm  = 32'hFFFF_FFFC;
    step("to_top");
    chk("top_pc", pc, 32'hFFFF_FFFC);
    clear_ctl();
    step("wrap");
    chk("wrap_pc", pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (m_trapped && $urandom_range(0, 3) == 0) begin
        clear_ctl();
        do_reset();
      end else begin
        stall      = ($urandom_range(0, 6) == 0);
        imem_ready = ($urandom_range(0, 3) != 0);
        branch     = ($urandom_range(0, 3) == 0);
        branch_ne  = $urandom_range(0, 1) == 1;
        eq         = $urandom_range(0, 1) == 1;
        jump       = ($urandom_range(0, 7) == 0);
        jalr       = ($urandom_range(0, 9) == 0);
        r          = $urandom;
        imm        = {r[31:2], 2'b00};
        if ($urandom_range(0, 15) == 0) imm[1] = 1'b1;
        if ($urandom_range(0, 1) == 0) imm = 32'd4;
        r          = $urandom;
        alu        = r;
        if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
        step("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
